mb_reset_seq: RTL and testbench
===============================

# mb_reset_seq

Reset and serial-gating controller for the modboard microcontroller (mb). It turns FTDI DTR transitions and a local push-button into a clean, minimum-width mb reset pulse followed by a boot lockout window. It gates the FTDI<->mb UART lines so that no glitch traffic crosses while the mb is held in reset, and drives the mb status LED from its state. It sits between the FTDI pins and the mb d0/d1/reset/LED pins and replaces their direct wiring.

## Interface
- SYNC_STAGES, 2, synchronizer depth for ftdi_dtr and btn_n (min 2)
- DEBOUNCE_CYCLES, 16, consecutive identical synchronized samples required to accept a new btn_n level
- RST_CYCLES, 1024, mb_rst_n low time in cycles (min 1)
- BOOT_CYCLES, 4096, lockout window after reset release (min 1)
- CNT_W, 16, width of the shared interval counter; must hold max(RST_CYCLES, BOOT_CYCLES)
- pG0  in  1  clock
- pRST  in  1  asynchronous, active-low reset
- ftdi_dtr  in  1  raw FTDI DTR pin, low = asserted
- btn_n  in  1  raw reset push-button, low = pressed
- ftdi_txd  in  1  FTDI TX data, destined for mb d0
- mb_txd  in  1  mb d1 TX data, destined for FTDI RX
- mb_rxd  out  1  to mb d0
- ftdi_rxd  out  1  to FTDI RX
- mb_rst_n  out  1  mb reset, low = in reset
- mb_led  out  1  status LED, high = lit

## Operation
- ftdi_dtr and btn_n each pass through a SYNC_STAGES flop synchronizer.
- DTR trigger: a one-cycle pulse on the synchronized 1->0 edge, from an edge register.
- btn_n debounce: a counter of DEBOUNCE_CYCLES. The debounced level changes only after that many consecutive equal samples. Any differing sample restarts the count. Reset value of the debounced level is 1 (released).
- State machine with three states:
  - RST: mb_rst_n=0; mb_rxd=1 and ftdi_rxd=1 (UART idle); mb_led=0. The counter counts up to RST_CYCLES. Exit to BOOT when the count reaches RST_CYCLES and the debounced button is released. A DTR trigger in RST clears the counter (retrigger). A held button keeps the FSM in RST indefinitely.
  - BOOT: mb_rst_n=1; UART passthrough enabled; mb_led = counter bit 8 (blink). The counter counts to BOOT_CYCLES, then the FSM goes to RUN. DTR triggers are ignored (lockout). A debounced button press goes to RST with the counter cleared.
  - RUN: mb_rst_n=1; passthrough enabled; mb_led=1. A DTR trigger or a debounced button press goes to RST with the counter cleared.
- Passthrough, combinational from a registered pass_en flag:
  - mb_rxd = pass_en ? ftdi_txd : 1
  - ftdi_rxd = pass_en ? mb_txd : 1
- Counter: CNT_W bits. It is cleared on every state entry and never wraps, because it is only compared for equality with the terminal count.
- Simultaneous DTR trigger and button press: both lead to RST; a single entry, counter cleared.

## Timing
- Reset (pRST low, asynchronous):
  - State is RST with the counter at 0.
  - Synchronizers and edge register hold 1.
  - pass_en=0, mb_rst_n=0, mb_rxd=1, ftdi_rxd=1, mb_led=0.
- After pRST deasserts, the FSM runs a full RST_CYCLES reset then BOOT_CYCLES lockout, so the mb always gets a power-on reset.
- mb_rst_n, mb_led and pass_en are registered outputs of the FSM, updated on pG0 rising edges.
- DTR latency: with SYNC_STAGES=2, mb_rst_n goes low at the 4th pG0 edge after the first edge that samples ftdi_dtr low (2 sync stages + edge register + state register). pass_en drops on the same edge.
- Reset width: mb_rst_n stays low for exactly RST_CYCLES cycles after the last retrigger, extended while the button is held.
- Button latency: the input must be stable for DEBOUNCE_CYCLES, plus SYNC_STAGES cycles, plus 1 state cycle, before RST is entered.
- A DTR pulse narrower than one pG0 period may be missed. Only edges held for ≥2 cycles are guaranteed.

## Test plan
Use RST_CYCLES=8, BOOT_CYCLES=16, DEBOUNCE_CYCLES=4.
- pRST low, then released:
  - During reset: mb_rst_n=0, mb_rxd=1, ftdi_rxd=1, mb_led=0, with ftdi_txd toggling.
  - mb_rst_n rises after 8 cycles.
  - mb_led blinks/holds per BOOT, then is 1 after 16 more cycles.
- In RUN, ftdi_dtr 1->0 held:
  - mb_rst_n low at the 4th edge, for exactly 8 cycles.
  - mb_rxd forced 1 throughout, despite ftdi_txd=0.
  - Passthrough restored in BOOT.
- Second DTR falling edge 5 cycles into RST -> mb_rst_n low for a total of 13 cycles. A DTR edge during BOOT -> no reset; RUN is reached on schedule.
- btn_n bouncing (low 2 cycles, high 1, low 6):
  - No reset until the stable run of 4 samples.
  - Held for 40 cycles -> mb_rst_n low for the entire hold, then 8 more cycles after the debounced release.
- Passthrough in RUN: ftdi_txd pattern 1,0,1,1,0 appears on mb_rxd, and mb_txd pattern appears on ftdi_rxd, each same-cycle (combinational).
- pRST asserted mid-BOOT -> all outputs go to their reset values immediately, without a clock edge, and the full sequence restarts on release.

Source files
------------

// File: rtl/mb_reset_seq_if.sv
// Pin bundle between the FTDI bridge, the push-button and the modboard mb.
// The controller takes the slave view; whatever drives the raw pins takes the master view.
interface mb_reset_seq_if;
    logic ftdi_dtr;
    logic btn_n;
    logic ftdi_txd;
    logic mb_txd;
    logic mb_rxd;
    logic ftdi_rxd;
    logic mb_rst_n;
    logic mb_led;

    modport master (
        output ftdi_dtr, btn_n, ftdi_txd, mb_txd,
        input  mb_rxd, ftdi_rxd, mb_rst_n, mb_led
    );

    modport slave (
        input  ftdi_dtr, btn_n, ftdi_txd, mb_txd,
        output mb_rxd, ftdi_rxd, mb_rst_n, mb_led
    );
endinterface

// File: rtl/mb_reset_seq.sv
// Reset and UART-gating controller for the mb: DTR/button -> minimum-width reset,
// then a boot lockout window, with the serial lines held idle while mb is in reset.
module mb_reset_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RST_CYCLES      = 1024,
    parameter int BOOT_CYCLES     = 4096,
    parameter int CNT_W           = 16
) (
    input  logic          pG0,
    input  logic          pRST,
    mb_reset_seq_if.slave bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LED_BIT = (CNT_W > 8) ? 8 : CNT_W - 1;

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST,
        ST_BOOT,
        ST_RUN
    } state_t;

    logic [SYNC_STAGES-1:0] dtr_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   dtr_s;
    logic                   btn_s;

    // Both raw pins idle high, so the synchronizers reset to 1 to avoid a
    // phantom DTR edge or button press right after pRST releases.
    always_ff @(posedge pG0 or negedge pRST) begin
        if (!pRST) begin
            dtr_sync <= '1;
            btn_sync <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value and the chain shifts one stage per clock.
            dtr_sync <= {dtr_sync[SYNC_STAGES-2:0], bus.ftdi_dtr};
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], bus.btn_n};
        end
    end

    assign dtr_s = dtr_sync[SYNC_STAGES-1];
    assign btn_s = btn_sync[SYNC_STAGES-1];

    logic dtr_prev;
    logic dtr_trig;

    always_ff @(posedge pG0 or negedge pRST) begin
        if (!pRST) begin
            dtr_prev <= 1'b1;
            dtr_trig <= 1'b0;
        end else begin
            dtr_prev <= dtr_s;
            dtr_trig <= dtr_prev & ~dtr_s;
        end
    end

    logic            btn_db;
    logic [DB_W-1:0] db_cnt;

    // A sample matching the accepted level restarts the run of new-level samples.
    always_ff @(posedge pG0 or negedge pRST) begin
        if (!pRST) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    logic             press;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             pass_en;
    logic             rst_n_q;
    logic             led_q;

    assign press   = ~btn_db;
    assign cnt_inc = cnt + CNT_W'(1);

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge pG0 or negedge pRST) begin
        if (!pRST) begin
            state   <= ST_RST;
            cnt     <= '0;
            pass_en <= 1'b0;
            rst_n_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_RST: begin
                    // A held button counts as a continuous retrigger.
                    if (dtr_trig || press) begin
                        cnt <= '0;
                    end else if (cnt == RST_LAST) begin
                        state   <= ST_BOOT;
                        cnt     <= '0;
                        pass_en <= 1'b1;
                        rst_n_q <= 1'b1;
                        led_q   <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_BOOT: begin
                    if (press) begin
                        state   <= ST_RST;
                        cnt     <= '0;
                        pass_en <= 1'b0;
                        rst_n_q <= 1'b0;
                        led_q   <= 1'b0;
                    end else if (cnt == BOOT_LAST) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        led_q   <= 1'b1;
                    end else begin
                        cnt   <= cnt_inc;
                        led_q <= cnt_inc[LED_BIT];
                    end
                end
                ST_RUN: begin
                    if (dtr_trig || press) begin
                        state   <= ST_RST;
                        cnt     <= '0;
                        pass_en <= 1'b0;
                        rst_n_q <= 1'b0;
                        led_q   <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_RST;
                    cnt     <= '0;
                    pass_en <= 1'b0;
                    rst_n_q <= 1'b0;
                    led_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mb_rxd   = pass_en ? bus.ftdi_txd : 1'b1;
    assign bus.ftdi_rxd = pass_en ? bus.mb_txd   : 1'b1;
    assign bus.mb_rst_n = rst_n_q;
    assign bus.mb_led   = led_q;

endmodule

// File: tb/tb_mb_reset_seq.sv
// Directed bench for mb_reset_seq; mb_rst_n edges are checked by a scoreboard
// against expected (edge number, level) pairs queued by the stimulus.
module tb_mb_reset_seq;

    logic pG0  = 1'b0;
    logic pRST = 1'b0;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int   cyc;
        logic val;
    } exp_t;

    exp_t exp_q[$];

    mb_reset_seq_if bus ();

    mb_reset_seq #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .RST_CYCLES     (8),
        .BOOT_CYCLES    (16),
        .CNT_W          (16)
    ) dut (
        .pG0 (pG0),
        .pRST(pRST),
        .bus (bus)
    );

    always #5 pG0 = ~pG0;

    always @(posedge pG0) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge pG0);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_edge(input int c, input logic v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed mb_rst_n transition must match the next queued expectation.
    logic prev_rst = 1'b0;
    always @(negedge pG0) begin
        if (bus.mb_rst_n !== prev_rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rst_edge_unexpected: mb_rst_n went %0b at edge %0d, none expected",
                         bus.mb_rst_n, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rst_edge_cycle", cyc, e.cyc);
                check("rst_edge_level", bus.mb_rst_n, e.val);
            end
            prev_rst = bus.mb_rst_n;
        end
    end

    initial begin
        int n;
        int p;
        logic tx_pat [5];
        logic rx_pat [5];
        tx_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rx_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        bus.ftdi_dtr = 1'b1;
        bus.btn_n    = 1'b1;
        bus.ftdi_txd = 1'b0;
        bus.mb_txd   = 1'b0;

        // Power-on reset: outputs idle regardless of ftdi_txd.
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            bus.ftdi_txd = (i % 2 == 0);
            #1;
            check("por_mb_rst_n", bus.mb_rst_n, 0);
            check("por_mb_rxd", bus.mb_rxd, 1);
            check("por_ftdi_rxd", bus.ftdi_rxd, 1);
            check("por_mb_led", bus.mb_led, 0);
        end

        tick();
        pRST = 1'b1;
        p = cyc;
        expect_edge(p + 8, 1'b1);
        wait_to(p + 8);
        bus.ftdi_txd = 1'b0;
        #1 check("boot_pass_0", bus.mb_rxd, 0);
        bus.ftdi_txd = 1'b1;
        #1 check("boot_pass_1", bus.mb_rxd, 1);
        check("boot_led", bus.mb_led, 0);
        wait_to(p + 23);
        check("boot_led_end", bus.mb_led, 0);
        wait_to(p + 24);
        check("run_led", bus.mb_led, 1);

        // DTR in RUN: reset at the 4th edge, UART idled for the whole reset.
        tick();
        n = cyc;
        bus.ftdi_dtr = 1'b0;
        bus.ftdi_txd = 1'b0;
        expect_edge(n + 4, 1'b0);
        expect_edge(n + 12, 1'b1);
        for (int c = 1; c < 12; c++) begin
            wait_to(n + c);
            check("dtr_mb_rxd_gate", bus.mb_rxd, (c >= 4) ? 1 : 0);
        end
        wait_to(n + 12);
        check("dtr_boot_pass", bus.mb_rxd, 0);
        // DTR edge during BOOT is locked out.
        bus.ftdi_dtr = 1'b1;
        wait_to(n + 15);
        bus.ftdi_dtr = 1'b0;
        wait_to(n + 27);
        check("lockout_led_boot", bus.mb_led, 0);
        wait_to(n + 28);
        check("lockout_led_run", bus.mb_led, 1);
        check("lockout_rst_n", bus.mb_rst_n, 1);
        bus.ftdi_dtr = 1'b1;
        repeat (6) tick();

        // Retrigger 5 cycles into RST: 13 cycles low in total.
        n = cyc;
        bus.ftdi_dtr = 1'b0;
        expect_edge(n + 4, 1'b0);
        expect_edge(n + 17, 1'b1);
        wait_to(n + 2);
        bus.ftdi_dtr = 1'b1;
        wait_to(n + 5);
        bus.ftdi_dtr = 1'b0;
        wait_to(n + 32);
        check("retrig_led_boot", bus.mb_led, 0);
        wait_to(n + 33);
        check("retrig_led_run", bus.mb_led, 1);
        bus.ftdi_dtr = 1'b1;
        repeat (6) tick();

        // Bouncing button, then a long hold and release.
        n = cyc;
        bus.btn_n = 1'b0;
        expect_edge(n + 10, 1'b0);
        expect_edge(n + 57, 1'b1);
        wait_to(n + 2);
        bus.btn_n = 1'b1;
        wait_to(n + 3);
        bus.btn_n = 1'b0;
        wait_to(n + 40);
        check("btn_hold_rst_n", bus.mb_rst_n, 0);
        check("btn_hold_led", bus.mb_led, 0);
        wait_to(n + 43);
        bus.btn_n = 1'b1;
        wait_to(n + 72);
        check("btn_led_boot", bus.mb_led, 0);
        wait_to(n + 73);
        check("btn_led_run", bus.mb_led, 1);

        // Combinational passthrough in RUN, both directions.
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.ftdi_txd = tx_pat[i];
            bus.mb_txd   = rx_pat[i];
            #1;
            check("pass_mb_rxd", bus.mb_rxd, tx_pat[i]);
            check("pass_ftdi_rxd", bus.ftdi_rxd, rx_pat[i]);
        end

        // Asynchronous reset in the middle of BOOT.
        tick();
        n = cyc;
        bus.ftdi_dtr = 1'b0;
        expect_edge(n + 4, 1'b0);
        expect_edge(n + 12, 1'b1);
        wait_to(n + 2);
        bus.ftdi_dtr = 1'b1;
        wait_to(n + 17);
        bus.ftdi_txd = 1'b0;
        bus.mb_txd   = 1'b0;
        #1;
        check("mid_boot_mb_rxd", bus.mb_rxd, 0);
        check("mid_boot_ftdi_rxd", bus.ftdi_rxd, 0);
        pRST = 1'b0;
        expect_edge(cyc, 1'b0);
        #1;
        check("async_mb_rst_n", bus.mb_rst_n, 0);
        check("async_mb_rxd", bus.mb_rxd, 1);
        check("async_ftdi_rxd", bus.ftdi_rxd, 1);
        check("async_mb_led", bus.mb_led, 0);
        repeat (3) tick();
        pRST = 1'b1;
        p = cyc;
        expect_edge(p + 8, 1'b1);
        wait_to(p + 7);
        check("rerun_rst_n_low", bus.mb_rst_n, 0);
        wait_to(p + 23);
        check("rerun_led_boot", bus.mb_led, 0);
        wait_to(p + 24);
        check("rerun_led_run", bus.mb_led, 1);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
